// File: rtl/sdram_read_arbiter_pkg.sv
// Shared types and widths for the SDRAM read-port arbiter and its helper blocks.
package sdram_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam int SDRAM_ADDR_W = 28;
  localparam int SDRAM_SIZE_W = 32;
  localparam int SDRAM_DATA_W = 16;
  localparam int IDX_W        = 3;

  // Advance a requester index, wrapping from n-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned      n);
    if (32'(idx) == n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/sdram_read_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module sdram_read_arbiter_rr_picker
  import sdram_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int pos;
    valid = 1'b0;
    index = '0;
    pos   = 0;
    // Walk farthest-first so the nearest requester from ptr is the last writer.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) begin
        valid = 1'b1;
        index = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller read port between NUM_REQ
// requesters; one owner per burst, released on burst end, NAK or first-fill timeout.
module sdram_read_arbiter
  import sdram_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_BITS = 10
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_req,
  input  logic [NUM_REQ*SDRAM_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*SDRAM_SIZE_W-1:0] req_size,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              req_nak,
  output logic [NUM_REQ-1:0]              req_fill,
  output logic [SDRAM_DATA_W-1:0]         req_data,
  output logic [SDRAM_ADDR_W-1:0]         sdram_addr,
  output logic                            sdram_req,
  output logic [SDRAM_SIZE_W-1:0]         sdram_size,
  input  logic                            sdram_ack,
  input  logic                            sdram_nak,
  input  logic                            sdram_fill,
  input  logic [SDRAM_DATA_W-1:0]         sdram_data,
  output logic                            busy,
  output logic [IDX_W-1:0]                owner
);

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);
  localparam bit                 TO_EN    = (TIMEOUT != 0);

  arb_state_t              state, state_nx;
  logic [IDX_W-1:0]        ptr, ptr_nx, owner_nx, owner_next;
  logic [IDX_W-1:0]        pick_index;
  logic                    pick_valid;
  logic [SDRAM_ADDR_W-1:0] addr_nx;
  logic [SDRAM_SIZE_W-1:0] size_nx;
  logic                    req_nx;
  logic [TO_BITS-1:0]      count, count_nx;
  logic                    to_nak, to_nak_nx;
  logic                    active;
  logic [NUM_REQ-1:0]      owner_sel;

  sdram_read_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req   (req_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_index)
  );

  assign owner_next = wrap_inc(owner, NUM_REQ);

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    owner_nx  = owner;
    addr_nx   = sdram_addr;
    size_nx   = sdram_size;
    req_nx    = sdram_req;
    count_nx  = count;
    to_nak_nx = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nx = pick_index;
          addr_nx  = req_addr[SDRAM_ADDR_W*int'(pick_index) +: SDRAM_ADDR_W];
          size_nx  = req_size[SDRAM_SIZE_W*int'(pick_index) +: SDRAM_SIZE_W];
          req_nx   = 1'b1;
          count_nx = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        // A refused or timed-out owner moves to the back of the rotation.
        if (sdram_nak) begin
          req_nx   = 1'b0;
          ptr_nx   = owner_next;
          state_nx = IDLE;
        end else if (sdram_fill) begin
          req_nx   = 1'b0;
          state_nx = XFER;
        end else if (sdram_ack) begin
          req_nx = 1'b0;
        end else if (TO_EN && count == TO_LIMIT) begin
          to_nak_nx = 1'b1;
          req_nx    = 1'b0;
          ptr_nx    = owner_next;
          state_nx  = IDLE;
        end else if (count != '1) begin
          count_nx = count + 1'b1;
        end
      end
      XFER: begin
        if (!sdram_fill) begin
          ptr_nx   = owner_next;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      sdram_addr <= '0;
      sdram_size <= '0;
      sdram_req  <= 1'b0;
      count      <= '0;
      to_nak     <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      owner      <= owner_nx;
      sdram_addr <= addr_nx;
      sdram_size <= size_nx;
      sdram_req  <= req_nx;
      count      <= count_nx;
      to_nak     <= to_nak_nx;
    end
  end

  always_comb begin
    owner_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_sel[i] = (owner == IDX_W'(i));
  end

  // Controller handshakes reach only the owner; the timeout NAK lands one cycle
  // after the decision, when the FSM is already back in IDLE.
  assign active   = (state == REQ) || (state == XFER);
  assign req_ack  = owner_sel & {NUM_REQ{sdram_ack & active}};
  assign req_fill = owner_sel & {NUM_REQ{sdram_fill & active}};
  assign req_nak  = owner_sel & {NUM_REQ{(sdram_nak & active) | to_nak}};
  assign req_data = sdram_data;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: directed scenarios plus a randomized run against
// a queue-free round-robin reference model of grants and handshakes.
module tb_sdram_read_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_req;
  logic [N*28-1:0] req_addr;
  logic [N*32-1:0] req_size;
  logic [N-1:0]    req_ack, req_nak, req_fill;
  logic [15:0]     req_data;
  logic [27:0]     sdram_addr;
  logic            sdram_req;
  logic [31:0]     sdram_size;
  logic            sdram_ack, sdram_nak, sdram_fill;
  logic [15:0]     sdram_data;
  logic            busy;
  logic [2:0]      owner;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ptr_m;
  int          cur_owner;
  int          fill_cnt;
  logic [27:0] addr_m [N];
  logic [31:0] size_m [N];
  logic [N-1:0] zero = '0;

  always #5 clock = ~clock;

  sdram_read_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO),
    .TO_BITS (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_req    (req_req),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_ack    (req_ack),
    .req_nak    (req_nak),
    .req_fill   (req_fill),
    .req_data   (req_data),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_size (sdram_size),
    .sdram_ack  (sdram_ack),
    .sdram_nak  (sdram_nak),
    .sdram_fill (sdram_fill),
    .sdram_data (sdram_data),
    .busy       (busy),
    .owner      (owner)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  // Reference rule: first requester set, scanning ptr, ptr+1, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_reqs(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      addr_m[i] = 28'($urandom);
      size_m[i] = $urandom_range(1, 64);
      req_addr[28*i +: 28] = addr_m[i];
      req_size[32*i +: 32] = size_m[i];
    end
    req_req = v;
  endtask

  task automatic apply_reset();
    logic [127:0] got, want;
    tick();
    reset = 1'b1; req_req = '0; sdram_ack = 1'b0; sdram_nak = 1'b0; sdram_fill = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    got  = 128'({sdram_req, busy, owner, req_ack, req_nak, req_fill, sdram_addr, sdram_size});
    want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", got, want);
    end
    ptr_m = 0;
  endtask

  task automatic wait_grant();
    logic [127:0] got, want;
    int  want_idx;
    int  lat;
    bit  seen;
    want_idx = model_pick(req_req, ptr_m);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      #2;
      lat = i + 1;
      if (sdram_req === 1'b1) seen = 1'b1;
    end
    cur_owner = want_idx;
    n_checks++;
    if (!seen || lat != 1) begin
      n_fail++;
      $display("FAIL grant_latency: got %0d cycles (seen=%0b) want 1", lat, seen);
      return;
    end
    got  = 128'({busy, owner, sdram_addr, sdram_size});
    want = 128'({1'b1, 3'(want_idx), addr_m[want_idx], size_m[want_idx]});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL grant_owner: got %h want %h", got, want);
    end
  endtask

  task automatic run_burst(input int ack_dly, input int nfill, input bit same,
                           input logic [N-1:0] next);
    logic [127:0] got, want;
    logic [N-1:0] o;
    logic [15:0]  d;
    int           rest;
    o = oh(cur_owner);
    for (int k = 1; k < ack_dly; k++) begin
      tick();
      #2;
      got  = 128'({sdram_req, req_ack, req_fill, req_nak});
      want = 128'({1'b1, zero, zero, zero});
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wait_ack: got %h want %h", got, want);
      end
    end
    tick();
    sdram_ack = 1'b1;
    d = 16'($urandom);
    if (same) begin
      sdram_fill = 1'b1;
      sdram_data = d;
    end
    #2;
    if (same && req_fill[cur_owner] === 1'b1) fill_cnt++;
    got  = 128'({sdram_req, req_ack, req_fill, (same ? req_data : 16'h0)});
    want = 128'({1'b1, o, (same ? o : zero), (same ? d : 16'h0)});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL ack_cycle: got %h want %h", got, want);
    end
    rest = same ? nfill - 1 : nfill;
    for (int k = 0; k < rest; k++) begin
      tick();
      req_req[cur_owner] = 1'b0;
      sdram_ack  = 1'b0;
      d          = 16'($urandom);
      sdram_fill = 1'b1;
      sdram_data = d;
      #2;
      if (req_fill[cur_owner] === 1'b1) fill_cnt++;
      got  = 128'({sdram_req, busy, req_ack, req_fill, req_data, sdram_addr, sdram_size});
      want = 128'({1'b0, 1'b1, zero, o, d, addr_m[cur_owner], size_m[cur_owner]});
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fill_cycle: got %h want %h", got, want);
      end
    end
    tick();
    req_req[cur_owner] = 1'b0;
    sdram_ack  = 1'b0;
    sdram_fill = 1'b0;
    #2;
    got  = 128'({sdram_req, busy, req_ack, req_fill});
    want = 128'({1'b0, 1'b1, zero, zero});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL burst_end: got %h want %h", got, want);
    end
    tick();
    set_reqs(next);
    #2;
    got  = 128'({sdram_req, busy, req_ack, req_fill, req_nak});
    want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL dead_cycle: got %h want %h", got, want);
    end
    ptr_m = (cur_owner + 1) % N;
  endtask

  task automatic run_nak(input int dly, input logic [N-1:0] next);
    logic [127:0] got, want;
    logic [N-1:0] o;
    o = oh(cur_owner);
    for (int k = 1; k < dly; k++) begin
      tick();
      #2;
      got  = 128'({sdram_req, req_nak});
      want = 128'({1'b1, zero});
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wait_nak: got %h want %h", got, want);
      end
    end
    tick();
    sdram_nak = 1'b1;
    #2;
    got  = 128'({sdram_req, req_nak, req_ack});
    want = 128'({1'b1, o, zero});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL nak_route: got %h want %h", got, want);
    end
    tick();
    sdram_nak = 1'b0;
    set_reqs(next);
    #2;
    got  = 128'({sdram_req, busy, req_nak});
    want = 128'({1'b0, 1'b0, zero});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL nak_release: got %h want %h", got, want);
    end
    ptr_m = (cur_owner + 1) % N;
  endtask

  task automatic run_timeout(input logic [N-1:0] next);
    logic [127:0] got, want;
    logic [N-1:0] o;
    o = oh(cur_owner);
    for (int k = 1; k <= TO; k++) begin
      tick();
      #2;
      got  = 128'({sdram_req, busy, req_nak});
      want = 128'({1'b1, 1'b1, zero});
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout_wait k=%0d: got %h want %h", k, got, want);
      end
    end
    tick();
    req_req = '0;
    #2;
    got  = 128'({sdram_req, busy, req_nak});
    want = 128'({1'b0, 1'b0, o});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %h want %h", got, want);
    end
    tick();
    set_reqs(next);
    #2;
    got  = 128'({busy, req_nak});
    want = 128'({1'b0, zero});
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL timeout_single: got %h want %h", got, want);
    end
    ptr_m = (cur_owner + 1) % N;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    reset = 1'b1;
    set_reqs(4'hF);
    for (int k = 0; k < 2; k++) begin
      tick();
      #2;
      n_checks++;
      if ({sdram_req, busy, owner} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got %b want 00000", {sdram_req, busy, owner});
      end
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    fill_cnt = 0;
    tick();
    set_reqs(4'b0100);
    addr_m[2] = 28'h0001000;
    size_m[2] = 32'd4;
    req_addr[56 +: 28] = addr_m[2];
    req_size[64 +: 32] = size_m[2];
    #2;
    n_checks++;
    if (sdram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_early_req: got %b want 0", sdram_req);
    end
    wait_grant();
    run_burst(2, 4, 1'b0, 4'b0000);
    n_checks++;
    if (fill_cnt != 4) begin
      n_fail++;
      $display("FAIL single_fill_count: got %0d want 4", fill_cnt);
    end
  endtask

  task automatic test_fairness();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    tick();
    set_reqs(4'hF);
    for (int b = 0; b < 5; b++) begin
      wait_grant();
      n_checks++;
      if (owner !== 3'(order[b])) begin
        n_fail++;
        $display("FAIL fair_order b=%0d: got %0d want %0d", b, owner, order[b]);
      end
      run_burst(1, 2, 1'b0, 4'hF);
    end
  endtask

  task automatic test_nak();
    apply_reset();
    tick();
    set_reqs(4'b0011);
    wait_grant();
    run_burst(1, 1, 1'b0, 4'b0011);
    wait_grant();
    n_checks++;
    if (owner !== 3'd1) begin
      n_fail++;
      $display("FAIL nak_setup_owner: got %0d want 1", owner);
    end
    run_nak(2, 4'b0011);
    wait_grant();
    n_checks++;
    if (owner !== 3'd0) begin
      n_fail++;
      $display("FAIL nak_next_grant: got %0d want 0", owner);
    end
    run_burst(1, 1, 1'b0, 4'b0000);
  endtask

  task automatic test_timeout();
    apply_reset();
    tick();
    set_reqs(4'b1000);
    wait_grant();
    run_timeout(4'b0000);
  endtask

  task automatic test_same_cycle();
    apply_reset();
    tick();
    set_reqs(4'b0010);
    wait_grant();
    fill_cnt = 0;
    run_burst(1, 3, 1'b1, 4'b0000);
    n_checks++;
    if (fill_cnt != 3) begin
      n_fail++;
      $display("FAIL same_fill_count: got %0d want 3", fill_cnt);
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic [127:0] got, want;
    apply_reset();
    tick();
    set_reqs(4'b0100);
    wait_grant();
    tick();
    sdram_ack = 1'b1; sdram_fill = 1'b1; sdram_data = 16'hBEEF;
    tick();
    sdram_ack = 1'b0;
    #2;
    n_checks++;
    if ({busy, req_fill} !== {1'b1, 4'b0100}) begin
      n_fail++;
      $display("FAIL mid_xfer_fill: got %b want 10100", {busy, req_fill});
    end
    tick();
    reset = 1'b1;
    req_req = '0;
    tick();
    reset = 1'b0;
    sdram_fill = 1'b0;
    #2;
    got  = 128'({sdram_req, busy, owner, req_nak, req_fill});
    want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_xfer_reset: got %h want %h", got, want);
    end
    ptr_m = 0;
    tick();
    set_reqs(4'b0010);
    wait_grant();
    run_burst(1, 2, 1'b0, 4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] nxt;
    int           kind;
    apply_reset();
    tick();
    set_reqs(4'($urandom_range(1, 15)));
    for (int it = 0; it < 40; it++) begin
      wait_grant();
      nxt  = 4'($urandom_range(1, 15));
      kind = $urandom_range(0, 9);
      if (kind < 5)      run_burst($urandom_range(1, 3), $urandom_range(1, 5), 1'b0, nxt);
      else if (kind < 7) run_burst($urandom_range(1, 3), $urandom_range(1, 4), 1'b1, nxt);
      else if (kind < 9) run_nak($urandom_range(1, 3), nxt);
      else               run_timeout(nxt);
    end
  endtask

  initial begin
    reset = 1'b1; req_req = '0; req_addr = '0; req_size = '0;
    sdram_ack = 1'b0; sdram_nak = 1'b0; sdram_fill = 1'b0; sdram_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_nak();
    test_timeout();
    test_same_cycle();
    test_reset_mid_xfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
